enc_input_conditioner: RTL
==========================

Name: enc_input_conditioner

Overview:
Front-end stage that sits directly upstream of the DAQ counter block. It takes the raw asynchronous encoder lines (A0/A1/Z0/Z1) and the ARM/SEL controls and conditions them: synchronization, glitch filtering, rising-edge pulse generation and per-channel glitch statistics. An arming FSM opens a measurement gate only at the first index (Z) pulse of the selected channel after ARM is asserted, so counting starts index-aligned.

Parameters:
P_SYNC_STAGES, 2, synchronizer flops per input (legal 2..4).
P_FILT_LEN, 1, consecutive post-sync cycles a new level must hold before it is accepted (legal 1..255; 1 = no filtering).
P_GLITCH_W, 16, width of the saturating glitch counters.

Ports:
ENC_CLK  in  1  encoder sampling clock; all logic on its rising edge
ResetN  in  1  synchronous active-low reset, sampled on ENC_CLK
I_A0, I_A1, I_Z0, I_Z1  in  1 each  raw asynchronous encoder lines
I_ARM  in  1  raw asynchronous arm request
I_SEL  in  1  raw reference select (0 = channel 0, 1 = channel 1)
O_A0, O_A1, O_Z0, O_Z1  out  1 each  filtered levels
O_A0_RISE, O_A1_RISE, O_Z0_RISE, O_Z1_RISE  out  1 each  one-cycle rising-edge pulses of the filtered levels
O_ARM  out  1  synchronized ARM
O_SEL  out  1  SEL latched at arming
O_GATE  out  1  high while FSM in RUN
O_START, O_STOP  out  1 each  one-cycle pulses on RUN entry / RUN exit
O_STATE  out  2  FSM state (00 IDLE, 01 WAIT_Z, 10 RUN)
O_GLITCH_A0, O_GLITCH_A1  out  P_GLITCH_W each  rejected-glitch counts

Behaviour:
- Reset (ResetN=0 at a clock edge): all sync flops, filter counters, outputs and glitch counters go to 0; O_STATE=IDLE. Reset is honoured mid-operation with the same result and has priority over all other events.
- Sync: I_A*/I_Z*/I_ARM/I_SEL each pass through a P_SYNC_STAGES flop chain. O_ARM is the last sync stage; ARM and SEL are not filtered.
- Filter, per A/Z line: an 8-bit counter increments each cycle the sync output differs from the filtered level. When it is at P_FILT_LEN-1 and the mismatch persists, the filtered level toggles and the counter clears. A match clears the counter.
- Latency: a level that is stable from capture edge 0 changes the filtered output after edge P_SYNC_STAGES+P_FILT_LEN-1. With the defaults this is edge 2.
- Rise pulse: *_RISE is registered together with the 0->1 toggle, so it is high for exactly the first cycle the filtered level is high.
- Glitch count (A0/A1 only): increments when a mismatch run ends with counter ≠ 0 because the input returned to the filtered level. It saturates at all-ones and is cleared only by reset. It never increments when P_FILT_LEN=1.
- FSM:
  - IDLE: on O_ARM=1, latch sync SEL into O_SEL and go to WAIT_Z.
  - WAIT_Z: O_ARM=0 goes to IDLE. Otherwise, Z rise of the channel in O_SEL (Z0_RISE when 0, Z1_RISE when 1) goes to RUN with O_START=1 for one cycle. Z of the non-selected channel is ignored.
  - RUN: O_GATE=1. O_ARM=0 goes to IDLE with O_STOP=1 for one cycle; O_GATE drops in that same cycle.
  - Further Z pulses in RUN are ignored.
- SEL changes after latching are ignored until the FSM returns to IDLE.
- Simultaneous ARM drop and selected Z rise in WAIT_Z: ARM has priority, so the FSM goes to IDLE with no O_START.
- Filtered A/Z outputs and rise pulses run continuously regardless of FSM state; gating is the consumer's job using O_GATE.

Test Plan:
- Reset: P_FILT_LEN=1, hold ResetN=0 for 3 cycles while driving all inputs high -> all outputs 0, O_STATE=00. Release -> O_A0 goes high 2 edges later and O_A0_RISE pulses for 1 cycle.
- Glitch reject: P_FILT_LEN=4, 2-cycle-wide A0 pulses ×10 -> O_A0 stays 0 and O_GLITCH_A0=10. Then a 4-cycle pulse -> one O_A0_RISE, O_GLITCH_A0 unchanged.
- Arm sequence: I_SEL=1, raise I_ARM, pulse Z0 then Z1 -> O_STATE 00→01, stays at 01 through Z0, goes to 10 on Z1_RISE with O_START one cycle. Then toggle I_SEL (no effect) and drop I_ARM -> O_STOP one cycle, O_GATE=0, O_STATE=00.
- Collision: in WAIT_Z, align I_ARM falling and the selected Z rising so both reach the FSM on the same edge -> O_STATE=00, O_START never asserted.
- Saturation: P_GLITCH_W=4, 20 rejected glitches -> O_GLITCH_A1 holds 15.
- Mid-run reset: in RUN, assert ResetN=0 for 1 cycle -> O_GATE=0, O_STATE=00, no O_STOP pulse. Re-arm without a Z pulse -> FSM remains in 01.

Source files
------------

// File: rtl/enc_input_conditioner_if.sv
// Encoder line bundle: raw lines in, conditioned levels,
// pulses, gate state and glitch statistics out.
interface enc_input_conditioner_if #(
  parameter int P_GLITCH_W = 16
);
  logic I_A0, I_A1, I_Z0, I_Z1;
  logic I_ARM, I_SEL;
  logic O_A0, O_A1, O_Z0, O_Z1;
  logic O_A0_RISE, O_A1_RISE;
  logic O_Z0_RISE, O_Z1_RISE;
  logic O_ARM, O_SEL;
  logic O_GATE, O_START, O_STOP;
  logic [1:0] O_STATE;
  logic [P_GLITCH_W-1:0] O_GLITCH_A0;
  logic [P_GLITCH_W-1:0] O_GLITCH_A1;

  modport master (
    output I_A0, I_A1, I_Z0, I_Z1,
    output I_ARM, I_SEL,
    input  O_A0, O_A1, O_Z0, O_Z1,
    input  O_A0_RISE, O_A1_RISE,
    input  O_Z0_RISE, O_Z1_RISE,
    input  O_ARM, O_SEL,
    input  O_GATE, O_START, O_STOP,
    input  O_STATE,
    input  O_GLITCH_A0, O_GLITCH_A1
  );

  modport slave (
    input  I_A0, I_A1, I_Z0, I_Z1,
    input  I_ARM, I_SEL,
    output O_A0, O_A1, O_Z0, O_Z1,
    output O_A0_RISE, O_A1_RISE,
    output O_Z0_RISE, O_Z1_RISE,
    output O_ARM, O_SEL,
    output O_GATE, O_START, O_STOP,
    output O_STATE,
    output O_GLITCH_A0, O_GLITCH_A1
  );
endinterface

// File: rtl/enc_input_conditioner.sv
// Encoder front end: sync, glitch filter, edge pulses,
// glitch statistics and index-aligned arming FSM.
module enc_input_conditioner #(
  parameter int P_SYNC_STAGES = 2,
  parameter int P_FILT_LEN    = 1,
  parameter int P_GLITCH_W    = 16
) (
  input logic ENC_CLK,
  input logic ResetN,
  enc_input_conditioner_if.slave bus
);
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_WAIT_Z = 2'b01,
    ST_RUN    = 2'b10
  } state_t;

  localparam logic [7:0] LP_LAST = 8'(P_FILT_LEN - 1);
  localparam logic [P_GLITCH_W-1:0] LP_SAT = '1;

  // bit order: A0 A1 Z0 Z1 ARM SEL (LSB first)
  logic [5:0] w_raw;
  logic [5:0] w_sync;
  logic [5:0] r_sync [P_SYNC_STAGES];
  logic [3:0] r_filt;
  logic [3:0] r_rise;
  logic [7:0] r_cnt [4];
  logic [P_GLITCH_W-1:0] r_glitch [2];
  state_t r_state;
  logic r_sel, r_gate, r_start, r_stop;
  logic w_arm, w_zsel;

  assign w_raw = {bus.I_SEL, bus.I_ARM, bus.I_Z1,
                  bus.I_Z0, bus.I_A1, bus.I_A0};
  assign w_sync = r_sync[P_SYNC_STAGES-1];
  assign w_arm  = w_sync[4];
  assign w_zsel = r_sel ? r_rise[3] : r_rise[2];

  always_ff @(posedge ENC_CLK) begin
    if (!ResetN) begin
      for (int i = 0; i < P_SYNC_STAGES; i++)
        r_sync[i] <= '0;
    end else begin
      r_sync[0] <= w_raw;
      for (int i = 1; i < P_SYNC_STAGES; i++)
        r_sync[i] <= r_sync[i-1];
    end
  end

  always_ff @(posedge ENC_CLK) begin
    if (!ResetN) begin
      r_filt <= '0;
      r_rise <= '0;
      for (int i = 0; i < 4; i++)
        r_cnt[i] <= '0;
      for (int i = 0; i < 2; i++)
        r_glitch[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        r_rise[i] <= 1'b0;
        if (w_sync[i] != r_filt[i]) begin
          if (r_cnt[i] == LP_LAST) begin
            r_filt[i] <= ~r_filt[i];
            r_rise[i] <= ~r_filt[i];
            r_cnt[i]  <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 8'd1;
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
      // a mismatch run that collapsed back is a rejected glitch
      for (int i = 0; i < 2; i++) begin
        if (w_sync[i] == r_filt[i] && r_cnt[i] != '0
            && r_glitch[i] != LP_SAT)
          r_glitch[i] <= r_glitch[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge ENC_CLK) begin
    if (!ResetN) begin
      r_state <= ST_IDLE;
      r_sel   <= 1'b0;
      r_gate  <= 1'b0;
      r_start <= 1'b0;
      r_stop  <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_stop  <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_arm) begin
            r_sel   <= w_sync[5];
            r_state <= ST_WAIT_Z;
          end
        end
        ST_WAIT_Z: begin
          // a dropping arm wins over a same-edge index
          if (!w_arm) begin
            r_state <= ST_IDLE;
          end else if (w_zsel) begin
            r_state <= ST_RUN;
            r_gate  <= 1'b1;
            r_start <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!w_arm) begin
            r_state <= ST_IDLE;
            r_gate  <= 1'b0;
            r_stop  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_gate  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.O_A0        = r_filt[0];
  assign bus.O_A1        = r_filt[1];
  assign bus.O_Z0        = r_filt[2];
  assign bus.O_Z1        = r_filt[3];
  assign bus.O_A0_RISE   = r_rise[0];
  assign bus.O_A1_RISE   = r_rise[1];
  assign bus.O_Z0_RISE   = r_rise[2];
  assign bus.O_Z1_RISE   = r_rise[3];
  assign bus.O_ARM       = w_arm;
  assign bus.O_SEL       = r_sel;
  assign bus.O_GATE      = r_gate;
  assign bus.O_START     = r_start;
  assign bus.O_STOP      = r_stop;
  assign bus.O_STATE     = r_state;
  assign bus.O_GLITCH_A0 = r_glitch[0];
  assign bus.O_GLITCH_A1 = r_glitch[1];
endmodule
